// File: rtl/cpu_pkg.sv
// Types shared by the CPU control path: sequencer states, opcode values and
// the instruction classes the sequencer and ALU control both switch on.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_GETREGS,
    S_EXEC,
    S_MEM,
    S_WB,
    S_INT,
    S_HALT
  } seq_state_t;

  localparam logic [3:0] OP_HALT   = 4'b0000;
  localparam logic [3:0] OP_ADD    = 4'b0001;
  localparam logic [3:0] OP_SUB    = 4'b0010;
  localparam logic [3:0] OP_LOAD   = 4'b0011;
  localparam logic [3:0] OP_STORE  = 4'b0100;
  localparam logic [3:0] OP_JMP    = 4'b0101;
  localparam logic [3:0] OP_JAL    = 4'b0110;
  localparam logic [3:0] OP_BRANCH = 4'b0111;
  localparam logic [3:0] OP_RETI   = 4'b1000;

  typedef enum logic [2:0] {
    CL_NOP,
    CL_HALT,
    CL_ARITH,
    CL_LOAD,
    CL_STORE,
    CL_JUMP,
    CL_BRANCH,
    CL_RETI
  } instr_class_t;

endpackage

// File: rtl/instr_class_decode.sv
// Combinational opcode-to-class decode; unlisted (illegal) opcodes fall to NOP.
module instr_class_decode
  import cpu_pkg::*;
(
  input  logic [3:0]   instrOP,
  output instr_class_t iclass
);

  always_comb begin
    case (instrOP)
      OP_HALT:        iclass = CL_HALT;
      OP_ADD, OP_SUB: iclass = CL_ARITH;
      OP_LOAD:        iclass = CL_LOAD;
      OP_STORE:       iclass = CL_STORE;
      OP_JMP, OP_JAL: iclass = CL_JUMP;
      OP_BRANCH:      iclass = CL_BRANCH;
      OP_RETI:        iclass = CL_RETI;
      default:        iclass = CL_NOP;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer with registered outputs and one-level interrupt.
// Define SEQ_TIMEOUT_EN to add the memory watchdog and the bus_error port.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] instrOP,
  input  logic       cond_true,
  input  logic       mem_done,
  input  logic       int_req,
  output logic       mem_start,
  output logic       mem_we,
  output logic       fetch,
  output logic       getRegs,
  output logic       reg_we,
  output logic       pc_inc,
  output logic       pc_jump,
  output logic       pc_vec,
  output logic       int_ack,
`ifdef SEQ_TIMEOUT_EN
  output logic       bus_error,
`endif
  output logic       halted
);

  seq_state_t   state, state_n;
  instr_class_t iclass, cls_q, cls_n, wb_cls;
  logic         in_isr, in_isr_n;
  logic         mem_start_n, mem_we_n, fetch_n, getregs_n, reg_we_n;
  logic         pc_inc_n, pc_jump_n, pc_vec_n, int_ack_n, halted_n;
  logic         done_ok, irq_ok, timeout;
  logic         go_fetch, go_wb, go_int, wb_nowrite;

  instr_class_decode u_decode (
    .instrOP (instrOP),
    .iclass  (iclass)
  );

  // A completion pulse coinciding with our own request is stale.
  assign done_ok = mem_done && !mem_start;
  assign irq_ok  = int_req && !in_isr;
  assign wb_cls  = (state == S_EXEC) ? iclass : cls_q;

  always_comb begin
    state_n     = state;
    cls_n       = cls_q;
    in_isr_n    = in_isr;
    mem_start_n = 1'b0;
    mem_we_n    = 1'b0;
    fetch_n     = 1'b0;
    getregs_n   = 1'b0;
    reg_we_n    = 1'b0;
    pc_inc_n    = 1'b0;
    pc_jump_n   = 1'b0;
    pc_vec_n    = 1'b0;
    int_ack_n   = 1'b0;
    halted_n    = 1'b0;
    go_fetch    = 1'b0;
    go_wb       = 1'b0;
    go_int      = 1'b0;
    wb_nowrite  = 1'b0;

    case (state)
      S_FETCH: begin
        // fetch low while in FETCH only happens straight out of reset.
        if (!fetch)        go_fetch = 1'b1;
        else if (done_ok) begin
          state_n   = S_GETREGS;
          getregs_n = 1'b1;
        end
        else if (timeout)  go_fetch = 1'b1;
        else               fetch_n  = 1'b1;
      end
      S_GETREGS: state_n = S_EXEC;
      S_EXEC: begin
        cls_n = iclass;
        case (iclass)
          CL_HALT: begin
            state_n  = S_HALT;
            halted_n = 1'b1;
          end
          CL_LOAD, CL_STORE: begin
            state_n     = S_MEM;
            mem_start_n = 1'b1;
            mem_we_n    = (iclass == CL_STORE);
          end
          default: go_wb = 1'b1;
        endcase
      end
      S_MEM: begin
        if (done_ok) go_wb = 1'b1;
        else if (timeout) begin
          go_wb      = 1'b1;
          wb_nowrite = 1'b1;
        end
      end
      S_WB: begin
        if (irq_ok) go_int   = 1'b1;
        else        go_fetch = 1'b1;
      end
      S_INT: go_fetch = 1'b1;
      S_HALT: begin
        if (irq_ok) go_int   = 1'b1;
        else        halted_n = 1'b1;
      end
      default: state_n = S_FETCH;
    endcase

    if (go_fetch) begin
      state_n     = S_FETCH;
      mem_start_n = 1'b1;
      fetch_n     = 1'b1;
    end
    if (go_int) begin
      state_n   = S_INT;
      int_ack_n = 1'b1;
      pc_vec_n  = 1'b1;
      in_isr_n  = 1'b1;
    end
    if (go_wb) begin
      state_n   = S_WB;
      reg_we_n  = !wb_nowrite && (wb_cls == CL_ARITH || wb_cls == CL_LOAD);
      pc_jump_n = (wb_cls == CL_JUMP) || (wb_cls == CL_RETI) ||
                  (wb_cls == CL_BRANCH && cond_true);
      pc_inc_n  = !pc_jump_n;
      if (wb_cls == CL_RETI) in_isr_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      cls_q     <= CL_NOP;
      in_isr    <= 1'b0;
      mem_start <= 1'b0;
      mem_we    <= 1'b0;
      fetch     <= 1'b0;
      getRegs   <= 1'b0;
      reg_we    <= 1'b0;
      pc_inc    <= 1'b0;
      pc_jump   <= 1'b0;
      pc_vec    <= 1'b0;
      int_ack   <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state     <= state_n;
      cls_q     <= cls_n;
      in_isr    <= in_isr_n;
      mem_start <= mem_start_n;
      mem_we    <= mem_we_n;
      fetch     <= fetch_n;
      getRegs   <= getregs_n;
      reg_we    <= reg_we_n;
      pc_inc    <= pc_inc_n;
      pc_jump   <= pc_jump_n;
      pc_vec    <= pc_vec_n;
      int_ack   <= int_ack_n;
      halted    <= halted_n;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] to_cnt;

  assign timeout = (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Every FETCH/MEM entry issues mem_start, so that marks a fresh wait window.
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt    <= '0;
      bus_error <= 1'b0;
    end else begin
      bus_error <= timeout && !done_ok &&
                   ((state == S_FETCH && fetch) || state == S_MEM);
      if (mem_start_n || (state_n != S_FETCH && state_n != S_MEM))
        to_cnt <= '0;
      else
        to_cnt <= to_cnt + CNT_W'(1);
    end
  end
`else
  assign timeout = 1'b0;
  wire unused_timeout_cfg = |TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed-vector bench for cpu_sequencer; outputs checked 1 time unit after each rising edge.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       reset, cond_true, mem_done, int_req;
  logic [3:0] instrOP;
  logic       mem_start, mem_we, fetch, getRegs, reg_we;
  logic       pc_inc, pc_jump, pc_vec, int_ack, halted;
`ifdef SEQ_TIMEOUT_EN
  logic       bus_error;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Bit order: mem_start mem_we fetch getRegs reg_we pc_inc pc_jump pc_vec int_ack halted
  localparam logic [9:0] E_0   = 10'b0000000000;
  localparam logic [9:0] E_FS  = 10'b1010000000;
  localparam logic [9:0] E_F   = 10'b0010000000;
  localparam logic [9:0] E_GR  = 10'b0001000000;
  localparam logic [9:0] E_MS  = 10'b1000000000;
  localparam logic [9:0] E_MSW = 10'b1100000000;
  localparam logic [9:0] E_WBW = 10'b0000110000;
  localparam logic [9:0] E_PI  = 10'b0000010000;
  localparam logic [9:0] E_PJ  = 10'b0000001000;
  localparam logic [9:0] E_INT = 10'b0000000110;
  localparam logic [9:0] E_H   = 10'b0000000001;

  wire [9:0] outs = {mem_start, mem_we, fetch, getRegs, reg_we,
                     pc_inc, pc_jump, pc_vec, int_ack, halted};

  always #5 clk = ~clk;

  cpu_sequencer #(.TIMEOUT_CYCLES(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .instrOP   (instrOP),
    .cond_true (cond_true),
    .mem_done  (mem_done),
    .int_req   (int_req),
    .mem_start (mem_start),
    .mem_we    (mem_we),
    .fetch     (fetch),
    .getRegs   (getRegs),
    .reg_we    (reg_we),
    .pc_inc    (pc_inc),
    .pc_jump   (pc_jump),
    .pc_vec    (pc_vec),
    .int_ack   (int_ack),
`ifdef SEQ_TIMEOUT_EN
    .bus_error (bus_error),
`endif
    .halted    (halted)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_done = 1'b0; int_req = 1'b0; cond_true = 1'b0; instrOP = 4'hF;
    step();
    step();
    n_cmp++;
    if (outs !== E_0) begin
      n_bad++;
      $display("FAIL reset: outs=%b expected %b", outs, E_0);
    end
    reset = 1'b0;
  endtask

  // ARITH with 1-cycle fetch: getRegs at cycle 3, WB at 5; next test sees mem_start at 6.
  task automatic test_arith();
    logic [9:0] ex[$];
    logic       dn[$];
    ex = '{E_FS, E_F, E_GR, E_0, E_WBW};
    dn = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    instrOP = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (outs !== ex[i]) begin
        n_bad++;
        $display("FAIL arith cyc%0d: outs=%b expected %b", i + 1, outs, ex[i]);
      end
      mem_done = dn[i];
    end
  endtask

  task automatic test_wb_classes();
    logic [3:0] ops[$];
    logic       cs[$];
    logic [9:0] wbs[$];
    logic [9:0] pat[$];
    logic [9:0] e;
    ops = '{4'h7, 4'h7, 4'h5, 4'h6, 4'h2, 4'h9, 4'hF};
    cs  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    wbs = '{E_PJ, E_PI, E_PJ, E_PJ, E_WBW, E_PI, E_PI};
    pat = '{E_FS, E_F, E_GR, E_0};
    for (int k = 0; k < 7; k++) begin
      instrOP   = ops[k];
      cond_true = cs[k];
      for (int j = 0; j < 5; j++) begin
        step();
        e = (j == 4) ? wbs[k] : pat[j];
        n_cmp++;
        if (outs !== e) begin
          n_bad++;
          $display("FAIL wb_class op=%h cyc%0d: outs=%b expected %b", ops[k], j + 1, outs, e);
        end
        mem_done = (j == 1);
      end
    end
    cond_true = 1'b0;
  endtask

  // LOAD with memory latency 4: 9 cycles in all.
  task automatic test_load();
    logic [9:0] ex[$];
    logic       dn[$];
    ex = '{E_FS, E_F, E_GR, E_0, E_MS, E_0, E_0, E_0, E_WBW};
    dn = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    instrOP = 4'b0011;
    for (int i = 0; i < 9; i++) begin
      step();
      n_cmp++;
      if (outs !== ex[i]) begin
        n_bad++;
        $display("FAIL load cyc%0d: outs=%b expected %b", i + 1, outs, ex[i]);
      end
      mem_done = dn[i];
    end
  endtask

  // mem_done raised alongside each mem_start must be ignored.
  task automatic test_store();
    logic [9:0] ex[$];
    logic       dn[$];
    ex = '{E_FS, E_F, E_GR, E_0, E_MSW, E_0, E_PI};
    dn = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    instrOP = 4'b0100;
    for (int i = 0; i < 7; i++) begin
      step();
      n_cmp++;
      if (outs !== ex[i]) begin
        n_bad++;
        $display("FAIL store cyc%0d: outs=%b expected %b", i + 1, outs, ex[i]);
      end
      mem_done = dn[i];
    end
    mem_done = 1'b0;
  endtask

  task automatic test_interrupt();
    logic [3:0] ops[$];
    logic       irpre[$];
    logic       irwb[$];
    logic       taken[$];
    logic [9:0] wbs[$];
    logic [9:0] pat[$];
    logic [9:0] e;
    ops   = '{4'h1, 4'h1, 4'h8, 4'h1, 4'h1, 4'h8};
    irpre = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    irwb  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    taken = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    wbs   = '{E_WBW, E_WBW, E_PJ, E_WBW, E_WBW, E_PJ};
    pat   = '{E_FS, E_F, E_GR, E_0};
    for (int k = 0; k < 6; k++) begin
      instrOP = ops[k];
      for (int j = 0; j < 5; j++) begin
        step();
        e = (j == 4) ? wbs[k] : pat[j];
        n_cmp++;
        if (outs !== e) begin
          n_bad++;
          $display("FAIL irq instr%0d cyc%0d: outs=%b expected %b", k, j + 1, outs, e);
        end
        mem_done = (j == 1);
        int_req  = (j == 4) ? irwb[k] : irpre[k];
      end
      if (taken[k]) begin
        step();
        n_cmp++;
        if (outs !== E_INT) begin
          n_bad++;
          $display("FAIL irq instr%0d int: outs=%b expected %b", k, outs, E_INT);
        end
      end
      int_req = 1'b0;
    end
  endtask

  task automatic test_halt();
    logic [9:0] pat[$];
    pat = '{E_FS, E_F, E_GR, E_0};
    instrOP = 4'b0000;
    for (int j = 0; j < 4; j++) begin
      step();
      n_cmp++;
      if (outs !== pat[j]) begin
        n_bad++;
        $display("FAIL halt entry cyc%0d: outs=%b expected %b", j + 1, outs, pat[j]);
      end
      mem_done = (j == 1);
    end
    for (int h = 0; h < 100; h++) begin
      step();
      n_cmp++;
      if (outs !== E_H) begin
        n_bad++;
        $display("FAIL halt hold%0d: outs=%b expected %b", h, outs, E_H);
      end
      int_req = (h == 99);
    end
    step();
    n_cmp++;
    if (outs !== E_INT) begin
      n_bad++;
      $display("FAIL halt wake: outs=%b expected %b", outs, E_INT);
    end
    int_req = 1'b0;
  endtask

  task automatic test_reset_mid_mem();
    logic [9:0] pre[$];
    logic [9:0] post[$];
    pre  = '{E_FS, E_F, E_GR, E_0, E_MS, E_0};
    post = '{E_FS, E_F, E_GR, E_0, E_WBW, E_INT};
    instrOP = 4'b0011;
    for (int j = 0; j < 6; j++) begin
      step();
      n_cmp++;
      if (outs !== pre[j]) begin
        n_bad++;
        $display("FAIL rstmem pre cyc%0d: outs=%b expected %b", j + 1, outs, pre[j]);
      end
      mem_done = (j == 1);
    end
    reset = 1'b1;
    for (int j = 0; j < 2; j++) begin
      step();
      n_cmp++;
      if (outs !== E_0) begin
        n_bad++;
        $display("FAIL rstmem in_reset%0d: outs=%b expected %b", j, outs, E_0);
      end
      mem_done = 1'b1;
    end
    reset = 1'b0;
    for (int j = 0; j < 6; j++) begin
      step();
      n_cmp++;
      if (outs !== post[j]) begin
        n_bad++;
        $display("FAIL rstmem post cyc%0d: outs=%b expected %b", j + 1, outs, post[j]);
      end
      mem_done = (j == 1);
      if (j == 1) instrOP = 4'b0001;
      int_req = (j == 4);
    end
    int_req = 1'b0;
  endtask

`ifdef SEQ_TIMEOUT_EN
  // Fetch retried after 8 silent cycles, then LOAD aborted after 8 in MEM.
  task automatic test_timeout();
    logic [9:0] e;
    logic       be;
    instrOP  = 4'b0011;
    mem_done = 1'b0;
    for (int i = 1; i <= 21; i++) begin
      step();
      e  = (i == 1 || i == 9)  ? E_FS :
           (i <= 8 || i == 10) ? E_F  :
           (i == 11)           ? E_GR :
           (i == 13)           ? E_MS :
           (i == 21)           ? E_PI : E_0;
      be = (i == 9 || i == 21);
      n_cmp++;
      if (outs !== e || bus_error !== be) begin
        n_bad++;
        $display("FAIL timeout cyc%0d: outs=%b bus_error=%b expected %b/%b",
                 i, outs, bus_error, e, be);
      end
      mem_done = (i == 10);
    end
    mem_done = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_arith();
    test_wb_classes();
    test_load();
    test_store();
    test_interrupt();
    test_halt();
    test_reset_mid_mem();
`ifdef SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
